// File: rtl/serial_negate_unit.sv
// Chunk-serial PASS / NEG / ABS unit for two's-complement operands.
// Processes CHUNK bits per clock and writes the result, OVF and ZERO on the last chunk.
module serial_negate_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] OUT,
    output logic             OVF,
    output logic             ZERO
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH - 1);
    localparam logic [1:0] MODE_NEG = 2'b01;
    localparam logic [1:0] MODE_ABS = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               negate;
    logic               last;
    int unsigned        shamt;
    logic [CHUNK-1:0]   chunk_in;
    logic [CHUNK-1:0]   chunk_inv;
    logic [CHUNK:0]     chunk_sum;
    logic [CHUNK-1:0]   chunk_res;

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        op_d    = op_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        // ABS negates only when the latched operand is negative; reserved mode passes through
        negate    = (mode_q == MODE_NEG) || ((mode_q == MODE_ABS) && op_q[WIDTH-1]);
        last      = (cnt_q == CNT_W'(N - 1));
        shamt     = 32'(cnt_q) * CHUNK;
        chunk_in  = CHUNK'(op_q >> shamt);
        chunk_inv = ~chunk_in;
        chunk_sum = (CHUNK+1)'(chunk_inv) + (CHUNK+1)'(carry_q);
        chunk_res = negate ? chunk_sum[CHUNK-1:0] : chunk_in;

        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    op_d    = IN;
                    mode_d  = MODE;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_q | (WIDTH'(chunk_res) << shamt);
                cnt_d = cnt_q + CNT_W'(1);
                if (negate) begin
                    carry_d = chunk_sum[CHUNK];
                end
                if (last) begin
                    out_d   = acc_d;
                    ovf_d   = negate && (op_q == MOST_NEG);
                    zero_d  = (acc_d == '0);
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= '0;
            mode_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign OUT  = out_q;
    assign OVF  = ovf_q;
    assign ZERO = zero_q;

endmodule

// File: tb/tb_serial_negate_unit.sv
// Scoreboard bench for serial_negate_unit: 8/2 and 16/4 instances, directed vectors.
module tb_serial_negate_unit;

    localparam logic [1:0] M_PASS = 2'b00;
    localparam logic [1:0] M_NEG  = 2'b01;
    localparam logic [1:0] M_ABS  = 2'b10;
    localparam logic [1:0] M_RSV  = 2'b11;
    localparam int LAT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, busy_a, done_a, ovf_a, zero_a;
    logic [1:0]  mode_a;
    logic [7:0]  in_a, out_a;
    logic        start_b, busy_b, done_b, ovf_b, zero_b;
    logic [1:0]  mode_b;
    logic [15:0] in_b, out_b;

    serial_negate_unit #(.WIDTH(8), .CHUNK(2)) dut_a (
        .CLK(clk), .RESETN(rst_n), .START(start_a), .MODE(mode_a), .IN(in_a),
        .BUSY(busy_a), .DONE(done_a), .OUT(out_a), .OVF(ovf_a), .ZERO(zero_a)
    );

    serial_negate_unit #(.WIDTH(16), .CHUNK(4)) dut_b (
        .CLK(clk), .RESETN(rst_n), .START(start_b), .MODE(mode_b), .IN(in_b),
        .BUSY(busy_b), .DONE(done_b), .OUT(out_b), .OVF(ovf_b), .ZERO(zero_b)
    );

    typedef struct packed {
        logic [15:0] out;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   done_cnt_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitors: pop expected value on every DONE pulse
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (done_a === 1'b1) begin
            done_cnt_a++;
            if (q_a.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_done_a: got DONE with no operation pending (t=%0t)", $time);
            end else begin
                e = q_a.pop_front();
                check("out_a", 32'(out_a), 32'(e.out));
                check("ovf_a", 32'(ovf_a), 32'(e.ovf));
                check("zero_a", 32'(zero_a), 32'(e.zero));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_done_b: got DONE with no operation pending (t=%0t)", $time);
            end else begin
                e = q_b.pop_front();
                check("out_b", 32'(out_b), 32'(e.out));
                check("ovf_b", 32'(ovf_b), 32'(e.ovf));
                check("zero_b", 32'(zero_b), 32'(e.zero));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; inputs are disturbed and START re-pulsed during RUN
    task automatic do_op(input bit b, input logic [1:0] m, input logic [15:0] x,
                         input logic [15:0] eo, input logic eov, input logic ez);
        exp_t e;
        int   cyc;
        logic d;
        e.out  = eo;
        e.ovf  = eov;
        e.zero = ez;
        if (b) begin
            start_b = 1'b1; mode_b = m; in_b = x; q_b.push_back(e);
        end else begin
            start_a = 1'b1; mode_a = m; in_a = x[7:0]; q_a.push_back(e);
        end
        tick();
        if (b) begin
            in_b = ~x; mode_b = m ^ 2'b01;
        end else begin
            in_a = ~x[7:0]; mode_a = m ^ 2'b01;
        end
        cyc = 13;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            d = b ? done_b : done_a;
            if (d === 1'b1) begin
                cyc = i;
                break;
            end
            if (i == 2) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check(b ? "latency_b" : "latency_a", 32'(cyc), 32'(LAT));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int cyc;
        rst_n = 1'b0;
        start_a = 1'b0; mode_a = '0; in_a = '0;
        start_b = 1'b0; mode_b = '0; in_b = '0;
        #12;
        check("reset_a", 32'({busy_a, done_a, ovf_a, zero_a, out_a}), 32'h0);
        check("reset_b", 32'({busy_b, done_b, ovf_b, zero_b, out_b}), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // NEG 01 with cycle-level BUSY/DONE/OUT-hold checks
        start_a = 1'b1; mode_a = M_NEG; in_a = 8'h01;
        q_a.push_back('{out: 16'h00FF, ovf: 1'b0, zero: 1'b0});
        tick();
        start_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("busy_run", 32'(busy_a), 32'd1);
            check("done_run", 32'(done_a), 32'd0);
            check("out_hold_run", 32'(out_a), 32'h0);
        end
        @(negedge clk);
        check("done_fin", 32'(done_a), 32'd1);
        check("busy_fin", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_one_cycle", 32'(done_a), 32'd0);
        check("busy_idle", 32'(busy_a), 32'd0);

        do_op(0, M_NEG,  16'h0080, 16'h0080, 1'b1, 1'b0);
        do_op(0, M_NEG,  16'h0000, 16'h0000, 1'b0, 1'b1);
        do_op(0, M_ABS,  16'h00F6, 16'h000A, 1'b0, 1'b0);
        do_op(0, M_ABS,  16'h0005, 16'h0005, 1'b0, 1'b0);
        do_op(0, M_ABS,  16'h0080, 16'h0080, 1'b1, 1'b0);
        do_op(0, M_RSV,  16'h003C, 16'h003C, 1'b0, 1'b0);
        do_op(0, M_PASS, 16'h0080, 16'h0080, 1'b0, 1'b0);
        do_op(0, M_PASS, 16'h0000, 16'h0000, 1'b0, 1'b1);
        do_op(0, M_NEG,  16'h007F, 16'h0081, 1'b0, 1'b0);
        do_op(0, M_NEG,  16'h0055, 16'h00AB, 1'b0, 1'b0);

        repeat (5) tick();
        check("hold_out", 32'({ovf_a, zero_a, out_a}), 32'h0AB);

        // Back-to-back with START held; IN changes during the first RUN
        start_a = 1'b1; mode_a = M_NEG; in_a = 8'h02;
        q_a.push_back('{out: 16'h00FE, ovf: 1'b0, zero: 1'b0});
        q_a.push_back('{out: 16'h0081, ovf: 1'b0, zero: 1'b0});
        d0 = done_cnt_a;
        tick();
        in_a = 8'h7F;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("b2b_busy1", 32'(busy_a), 32'd1);
        end
        @(negedge clk);
        check("b2b_done1", 32'(done_a), 32'd1);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        @(negedge clk);
        check("b2b_no_idle", 32'(busy_a), 32'd1);
        cyc = 11;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check("b2b_latency2", 32'(cyc), 32'd4);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        check("b2b_done_count", 32'(done_cnt_a - d0), 32'd2);
        check("b2b_idle_after", 32'({busy_a, done_a}), 32'h0);

        // Reset during the second RUN cycle abandons the operation
        start_a = 1'b1; mode_a = M_NEG; in_a = 8'h55;
        tick();
        start_a = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset", 32'({busy_a, done_a, ovf_a, zero_a, out_a}), 32'h0);
        d0 = done_cnt_a;
        repeat (3) tick();
        check("midrun_no_done", 32'(done_cnt_a - d0), 32'd0);
        rst_n = 1'b1;
        do_op(0, M_NEG, 16'h0003, 16'h00FD, 1'b0, 1'b0);

        // Wide instance
        do_op(1, M_NEG, 16'h0100, 16'hFF00, 1'b0, 1'b0);
        do_op(1, M_NEG, 16'h8000, 16'h8000, 1'b1, 1'b0);
        do_op(1, M_ABS, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op(1, M_NEG, 16'h0000, 16'h0000, 1'b0, 1'b1);

        repeat (2) tick();
        check("queues_drained", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_negate_unit.md
SERIAL_NEGATE_UNIT -- requirements
Module: serial_negate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 2, giving the bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RESETN  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  request to begin an operation.
REQ-006 MODE  input  2  operation select: 00 PASS, 01 NEG, 10 ABS, 11 reserved (treated as PASS).
REQ-007 IN  input  WIDTH  two's-complement operand.
REQ-008 BUSY  output  1  high while an operation is in progress.
REQ-009 DONE  output  1  one-cycle completion pulse.
REQ-010 OUT  output  WIDTH  registered result.
REQ-011 OVF  output  1  overflow flag for the last result.
REQ-012 ZERO  output  1  result-equals-zero flag for the last result.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN and FIN.
REQ-014 In IDLE or FIN, a rising edge with START=1 SHALL latch IN and MODE into internal registers, clear the chunk counter, load carry=1, and enter RUN; this edge is the accepting edge.
REQ-015 In RUN, each edge SHALL process the chunk [cnt*CHUNK+CHUNK-1 : cnt*CHUNK] of the latched operand and increment cnt.
  - NEG: result chunk = ~chunk + carry, and carry is updated to the chunk carry-out.
  - PASS: result chunk = chunk.
  - ABS: behaves as NEG if the latched operand's MSB is 1, otherwise as PASS.
REQ-016 Partial results SHALL accumulate in an internal register; OUT, OVF and ZERO SHALL change only at the edge completing the last chunk.
REQ-017 At the edge processing chunk N-1, the block SHALL write OUT, OVF and ZERO and enter FIN; total latency is N edges after the accepting edge.
REQ-018 DONE SHALL be 1 only in FIN, for exactly one cycle; BUSY SHALL be 1 only in RUN.
REQ-019 FIN SHALL return to IDLE on the next edge if START=0; if START=1 it accepts a new operation per REQ-014 (back-to-back operation).
REQ-020 START SHALL be ignored in RUN; MODE and IN changes during RUN SHALL not affect the result.
REQ-021 OVF SHALL be 1 only when the effective operation is a negation and the operand equals the most negative value (1 followed by WIDTH-1 zeros); the result is then that same value.
REQ-022 The final carry-out SHALL be discarded; NEG of 0 gives 0 with OVF=0.
REQ-023 ZERO SHALL equal 1 exactly when the written OUT is all zeros.
REQ-024 OUT, OVF and ZERO SHALL hold their values between operations until the next completion or reset.

Reset
REQ-025 While RESETN=0, the block SHALL, immediately and independently of CLK, force state=IDLE, cnt=0, carry=0, internal result=0, OUT=0, OVF=0, ZERO=0, BUSY=0 and DONE=0.
REQ-026 A reset asserted mid-RUN SHALL abandon the operation with no DONE pulse.
REQ-027 The first rising edge after RESETN deasserts SHALL be able to accept START.

Verification (WIDTH=8, CHUNK=2, N=4 unless stated)
REQ-028 NEG IN=8'h01 -> BUSY high for 4 cycles; DONE pulses once; OUT=8'hFF, OVF=0, ZERO=0; OUT unchanged until the 4th edge after accepting.
REQ-029 NEG IN=8'h80 -> OUT=8'h80, OVF=1. NEG IN=8'h00 -> OUT=8'h00, ZERO=1, OVF=0.
REQ-030 ABS IN=8'hF6 -> OUT=8'h0A. ABS IN=8'h05 -> OUT=8'h05. MODE=11 with IN=8'h3C -> OUT=8'h3C.
REQ-031 START held high continuously with NEG IN=8'h02, IN changed to 8'h7F during RUN:
  - first result OUT=8'hFE;
  - a second operation is accepted in FIN;
  - the second result is OUT=8'h81;
  - DONE pulses exactly twice, with no IDLE cycle between the operations.
REQ-032 RESETN pulsed low during the 2nd RUN cycle -> all outputs 0 immediately, no DONE; a following NEG IN=8'h03 -> OUT=8'hFD.
REQ-033 Instance with WIDTH=16, CHUNK=4: NEG IN=16'h0100 -> OUT=16'hFF00 after 4 edges; NEG IN=16'h8000 -> OVF=1.
